// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with one-entry skid buffer, flush and saturating stall counter
module pipe_skid_stage #(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] skid;
  always_comb begin
    state_nx = state == EMPTY ? (in_valid ? ONE : EMPTY) :
               state == ONE   ? (in_valid && !out_ready ? FULL : (!in_valid && out_ready ? EMPTY : ONE)) :
                                (out_ready ? ONE : FULL);
  end
  // Handshake outputs are registered from the next state so in_ready never sees out_ready combinationally
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      out_data  <= RESET_VAL;
      skid      <= RESET_VAL;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      state     <= state_nx;
      out_valid <= state_nx != EMPTY;
      in_ready  <= state_nx != FULL;
      occupancy <= state_nx;
      case (state)
        EMPTY: if (in_valid) out_data <= in_data;
        ONE: begin
          if (in_valid && out_ready) out_data <= in_data;
          else if (!in_valid && out_ready) out_data <= RESET_VAL;
          if (in_valid && !out_ready) skid <= in_data;
        end
        default: if (out_ready) begin
          out_data <= skid;
          skid     <= RESET_VAL;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst || stall_clr) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule
